sobel_stream_bridge: RTL and testbench

- Adapts an AXI4-Stream pixel source/sink to the fixed-latency, stall-driven Sobel convolution pipeline.
- Drives the pipeline's input beat and stall, and flushes the pipeline at end of frame.
- Discards warm-up outputs and buffers results in an output FIFO for an AXI4-Stream master with tlast.
- Resets the pipeline between frames so its row/column counters realign.

---
 rtl/sobel_stream_bridge.sv | 160 ++++++++++++++++
 tb/tb_sobel_stream_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_bridge.sv
// sobel_stream_bridge
//   Bridges an AXI4-Stream pixel source/sink to a fixed-latency, stall-driven
//   Sobel pipeline. Input beats are fed while output credit allows, the pipe
//   is flushed with zero beats at end of frame, warm-up results are dropped
//   by a keep-tag shifter and kept results are buffered in a FWFT FIFO that
//   feeds the AXI4-Stream master. The pipe is reset for one cycle between
//   frames so its internal row/column counters realign.
//
// Ports
//   clk, aresetn             clock, synchronous active-low reset
//   s_axis_t{data,valid,ready,last}  pixel input (tlast is only checked)
//   pipe_data, pipe_stall    beat and hold to the pipeline
//   pipe_aresetn             pipeline reset, active-low
//   pipe_out                 pipeline result
//   m_axis_t{data,valid,ready,last}  result output, tlast on beat N-1
//   frame_busy               first accepted beat .. tlast handshake
//   tlast_err                sticky input framing error
module sobel_stream_bridge #(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned PIPE_LATENCY    = 24,
  parameter int unsigned SKIP_BEATS      = IMAGE_DIM / PIXELS_PER_BEAT,
  parameter int unsigned FIFO_DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] pipe_data,
  output logic                  pipe_stall,
  output logic                  pipe_aresetn,
  input  logic [DATA_WIDTH-1:0] pipe_out,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  frame_busy,
  output logic                  tlast_err
);

  localparam int unsigned N    = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int unsigned F    = SKIP_BEATS + PIPE_LATENCY;
  localparam int unsigned EW   = $clog2(N + F + 1);
  localparam int unsigned OW   = $clog2(N + 1);
  localparam int unsigned IW   = $clog2(PIPE_LATENCY + 1);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + PIPE_LATENCY + 1);

  typedef enum logic [1:0] {FEED, FLUSH, DRAIN, RESTART} state_t;

  state_t                  state_q, state_d;
  logic [EW-1:0]           e_q;          // enabled-cycle index within frame
  logic [OW-1:0]           out_cnt_q;    // kept results pushed this frame
  logic [PIPE_LATENCY-1:0] tag_q;        // keep tags travelling with the pipe
  logic [IW-1:0]           inflight_q;   // number of set bits in tag_q
  logic                    frame_busy_q;
  logic                    tlast_err_q;

  logic [DATA_WIDTH:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_q, rd_q;
  logic [CNTW-1:0]         count_q;

  logic en, credit_ok, tag_in, tail, push, pop, head_last, feed_acc;

  // Credit reserves a FIFO slot for every kept beat still inside the pipe,
  // so a push can never find the FIFO full.
  assign credit_ok = (CW'(count_q) + CW'(inflight_q)) < CW'(FIFO_DEPTH);
  assign tag_in    = (e_q >= EW'(SKIP_BEATS)) && (e_q < EW'(SKIP_BEATS + N));
  assign tail      = tag_q[PIPE_LATENCY-1];
  assign push      = en & tail;
  assign head_last = mem_q[rd_q][DATA_WIDTH];
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign feed_acc  = (state_q == FEED) & s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d       = state_q;
    en            = 1'b0;
    s_axis_tready = 1'b0;
    pipe_data     = '0;
    case (state_q)
      FEED: begin
        s_axis_tready = credit_ok;
        pipe_data     = s_axis_tdata;
        en            = s_axis_tvalid & credit_ok;
        if (en && (e_q == EW'(N - 1))) state_d = FLUSH;
      end
      FLUSH: begin
        en = credit_ok;
        if (en && (e_q == EW'(N + F - 1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head_last) state_d = RESTART;
      end
      RESTART: state_d = FEED;
      default: state_d = RESTART;
    endcase
  end

  assign pipe_stall   = ~en;
  assign pipe_aresetn = aresetn & (state_q != RESTART);

  always_ff @(posedge clk) begin
    if (!aresetn) state_q <= RESTART;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!aresetn || (state_q == RESTART)) begin
      e_q        <= '0;
      out_cnt_q  <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
    end else if (en) begin
      e_q        <= e_q + EW'(1);
      tag_q      <= (tag_q << 1) | PIPE_LATENCY'(tag_in);
      inflight_q <= inflight_q + IW'(tag_in) - IW'(tail);
      out_cnt_q  <= out_cnt_q + OW'(tail);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      frame_busy_q <= 1'b0;
      tlast_err_q  <= 1'b0;
    end else begin
      if (feed_acc) frame_busy_q <= 1'b1;
      else if (pop && m_axis_tlast) frame_busy_q <= 1'b0;
      // In FEED the enabled-cycle index equals the accepted-beat count.
      if (feed_acc && (s_axis_tlast != (e_q == EW'(N - 1)))) tlast_err_q <= 1'b1;
    end
  end

  assign frame_busy = frame_busy_q;
  assign tlast_err  = tlast_err_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {(out_cnt_q == OW'(N - 1)), pipe_out};
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = mem_q[rd_q][DATA_WIDTH-1:0];
  assign m_axis_tlast  = m_axis_tvalid & head_last;

endmodule

// File: tb/tb_sobel_stream_bridge.sv
// Bench for sobel_stream_bridge: 64x64 frames of 16-pixel beats (N=256),
// pipeline latency 4, SKIP_BEATS 4. The pipeline is modelled as a pure
// delay of PIPE_LATENCY+SKIP_BEATS enabled cycles, so output beat k must
// equal input beat k of the same frame.
module tb_sobel_stream_bridge;

  localparam int PPB    = 16;
  localparam int DW     = 8 * PPB;
  localparam int DIM    = 64;
  localparam int PL     = 4;
  localparam int SKIP   = DIM / PPB;
  localparam int N      = DIM * DIM / PPB;
  localparam int F      = SKIP + PL;
  localparam int DLY    = PL + SKIP;
  localparam int BUDGET = 20000;

  logic          clk, aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] pipe_data, pipe_out;
  logic          pipe_stall, pipe_aresetn;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic          frame_busy, tlast_err;

  sobel_stream_bridge #(
    .PIXELS_PER_BEAT(PPB),
    .IMAGE_DIM(DIM),
    .PIPE_LATENCY(PL)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .pipe_aresetn(pipe_aresetn),
    .pipe_out(pipe_out),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .frame_busy(frame_busy),
    .tlast_err(tlast_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipeline model: delay line advancing on enabled cycles.
  logic [DW-1:0] dl [DLY];
  always @(posedge clk) begin
    if (!pipe_aresetn) begin
      for (int i = 0; i < DLY; i++) dl[i] <= '0;
    end else if (!pipe_stall) begin
      dl[0] <= pipe_data;
      for (int i = 1; i < DLY; i++) dl[i] <= dl[i-1];
    end
  end
  assign pipe_out = dl[DLY-1];

  typedef struct {
    int frame;
    int vpct;
    int rpct;
    int hold;
    int exp_hold_acc;
    int bad;
    bit exp_err;
    int exp_gap;
  } vec_t;

  vec_t tbl [7];

  int checks = 0, failures = 0;
  int cur_frame, src_k, vpct, rpct, bad_idx, out_k;
  bit src_active = 1'b0, sink_hold = 1'b0;
  int pl_low, pl_low_end, low_cnt, first_gap, flush_en, flush_bad, tl_cnt;

  function automatic logic [DW-1:0] beat_val(input int f, input int k);
    logic [7:0] fb, kb;
    fb = f[7:0];
    kb = k[7:0];
    return {8{fb, kb}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observe one cycle at the negedge, then drive the next cycle's inputs.
  task automatic cycle();
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    if (aresetn) begin
      if (!pipe_aresetn) pl_low++;
      if (!s_axis_tready) low_cnt++;
      else begin
        if (low_cnt != 0 && first_gap < 0) first_gap = low_cnt;
        low_cnt = 0;
      end
      if (src_active && src_k == N && !pipe_stall) begin
        flush_en++;
        if (pipe_data != '0 || s_axis_tready) flush_bad++;
      end
      acc = s_axis_tvalid && s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        chk("out_data", m_axis_tdata, beat_val(cur_frame, out_k));
        chk("out_last", DW'(m_axis_tlast), DW'(out_k == N - 1));
        if (out_k == 0) chk("busy_during_frame", DW'(frame_busy), 1);
        if (m_axis_tlast) tl_cnt++;
        out_k++;
        if (out_k == N) begin
          pl_low_end = pl_low;
          pl_low = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (acc) src_k++;
    if (src_active && src_k < N) begin
      if (!s_axis_tvalid || acc) s_axis_tvalid = ($urandom_range(99) < vpct);
      s_axis_tdata = beat_val(cur_frame, src_k);
      s_axis_tlast = (src_k == N - 1) || (src_k == bad_idx);
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
    m_axis_tready = sink_hold ? 1'b0 : ($urandom_range(99) < rpct);
  endtask

  task automatic apply_reset(input int n);
    aresetn       = 1'b0;
    src_active    = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    repeat (n) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    chk("rst_s_tready", DW'(s_axis_tready), 0);
    chk("rst_m_tvalid", DW'(m_axis_tvalid), 0);
    chk("rst_m_tlast", DW'(m_axis_tlast), 0);
    chk("rst_pipe_stall", DW'(pipe_stall), 1);
    chk("rst_pipe_aresetn", DW'(pipe_aresetn), 0);
    chk("rst_frame_busy", DW'(frame_busy), 0);
    chk("rst_tlast_err", DW'(tlast_err), 0);
    @(posedge clk);
    #1;
    low_cnt = 1;   // the restart cycle just observed
    pl_low  = 1;
    out_k   = 0;
  endtask

  task automatic start_src(input int f, input int vp, input int rp, input int bad);
    cur_frame  = f;
    src_k      = 0;
    src_active = 1'b1;
    vpct       = vp;
    rpct       = rp;
    bad_idx    = bad;
    out_k      = 0;
    flush_en   = 0;
    flush_bad  = 0;
    first_gap  = -1;
    tl_cnt     = 0;
  endtask

  task automatic run_frame(input vec_t v);
    int cyc;
    start_src(v.frame, v.vpct, v.rpct, v.bad);
    cyc = 0;
    while (out_k < N && cyc < BUDGET) begin
      sink_hold = (cyc < v.hold);
      cycle();
      cyc++;
      if (v.hold > 0 && cyc == v.hold) begin
        chk("hold_accepted", DW'(src_k), DW'(v.exp_hold_acc));
        chk("hold_s_tready", DW'(s_axis_tready), 0);
        chk("hold_m_tvalid", DW'(m_axis_tvalid), 1);
      end
    end
    sink_hold = 1'b0;
    chk("frame_out_beats", DW'(out_k), DW'(N));
    cycle();   // restart cycle
    chk("frame_busy_end", DW'(frame_busy), 0);
    chk("no_extra_output", DW'(m_axis_tvalid), 0);
    chk("tlast_count", DW'(tl_cnt), 1);
    chk("tlast_err", DW'(tlast_err), DW'(v.exp_err));
    chk("flush_en_cycles", DW'(flush_en), DW'(F));
    chk("flush_bad_cycles", DW'(flush_bad), 0);
    chk("pipe_rst_low_cycles", DW'(pl_low_end), 1);
    if (v.exp_gap >= 0) chk("s_tready_gap", DW'(first_gap), DW'(v.exp_gap));
  endtask

  initial begin
    int cyc;
    vec_t fin;
    tbl[0] = '{1, 100, 100,   0,  0,  -1, 1'b0,  1};
    tbl[1] = '{2, 100, 100,   0,  0,  -1, 1'b0, 10};
    tbl[2] = '{3, 100, 100, 100, 36,  -1, 1'b0, -1};
    tbl[3] = '{4,  50,  50,   0,  0,  -1, 1'b0, -1};
    tbl[4] = '{5,  50,  50,   0,  0,  -1, 1'b0, -1};
    tbl[5] = '{6,  50,  50,   0,  0,  -1, 1'b0, -1};
    tbl[6] = '{7, 100, 100,   0,  0, 100, 1'b1, -1};
    fin    = '{9, 100, 100,   0,  0,  -1, 1'b0,  1};

    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b0;
    pl_low = 0; pl_low_end = 0; low_cnt = 0; first_gap = -1;
    flush_en = 0; flush_bad = 0; tl_cnt = 0;
    cur_frame = 0; src_k = 0; vpct = 0; rpct = 0; bad_idx = -1; out_k = 0;

    apply_reset(3);
    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    // Reset in the middle of a frame, then a clean frame from beat 0.
    start_src(8, 100, 100, -1);
    cyc = 0;
    while (src_k < 150 && cyc < BUDGET) begin
      cycle();
      cyc++;
    end
    chk("mid_accepted", DW'(src_k), 150);
    chk("err_sticky", DW'(tlast_err), 1);
    apply_reset(1);
    run_frame(fin);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
